mix_column_engine: RTL
======================

MIX_COLUMN_ENGINE -- requirements
Module: mix_column_engine

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, columns processed per cycle; legal values 1, 2, 4.
REQ-002 Parameter OUT_REG, default 1, registers out_data when 1; out_data is a combinational view of the working register when 0.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data/in_mode valid.
REQ-006 in_ready  output  1  engine can accept a state.
REQ-007 in_data  input  128  AES state; column c = bits [127-32c -: 32]; row 0 byte in column MSB [31:24].
REQ-008 in_mode  input  1  0 = MixColumns (forward), 1 = InvMixColumns.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_data  output  128  transformed state, same column/byte layout as in_data.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states: IDLE, RUN, DONE; the encoding is free.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, capture in_data into the working register and in_mode into the mode register, clear the column counter, and go to RUN.
REQ-015 RUN: each cycle, replace columns [cnt*C .. cnt*C+C-1] with their transform and increment cnt; after the cycle with cnt = 4/C-1, go to DONE.
REQ-016 Latency from the accept edge to out_valid=1 is exactly 4/COLS_PER_CYCLE cycles: 4, 2 or 1.
REQ-017 DONE: out_valid=1 and out_data stable; on out_ready, go to IDLE.
REQ-018 out_valid and out_data hold unchanged while out_ready=0, for any number of cycles.
REQ-019 in_ready=0 in RUN and DONE; in_valid is ignored there, with no capture and no error.
REQ-020 There is no same-cycle DONE->accept bypass; at most one state is accepted per 4/C+2 cycles.
REQ-021 The mode is latched at accept; an in_mode change after accept has no effect on the block in flight.
REQ-022 Forward column transform, rows r0..r3: o_i = 2*r_i ^ 3*r_(i+1) ^ r_(i+2) ^ r_(i+3), indices mod 4, arithmetic in GF(2^8) mod x^8+x^4+x^3+x+1.
REQ-023 Inverse column transform: o_i = e*r_i ^ b*r_(i+1) ^ d*r_(i+2) ^ 9*r_(i+3).
REQ-024 Multiplication SHALL be computed with xtime chains and XOR; there are no 256-entry tables.
REQ-025 Inverse(Forward(x)) = x for every 128-bit x.
REQ-026 out_valid is low and out_data is 0 in IDLE and RUN when OUT_REG=1.

Reset
REQ-027 rst_n low: state=IDLE, cnt=0, working register=0, mode=0, out_data=0, out_valid=0, busy=0, and in_ready=1 after deassertion.
REQ-028 Reset asserted in RUN or DONE abandons the block immediately with no out_valid pulse; the first in_valid after rst_n rises is accepted normally.
REQ-029 Reset deassertion is synchronised externally; the block adds no synchroniser.

Structure
REQ-030 Shared package aes_pkg: gf_xtime/gf_mul function, MODE_FWD/MODE_INV constants, FSM state typedef.
REQ-031 Sub-module mix_column_unit: one 32-bit column plus a mode bit, purely combinational; COLS_PER_CYCLE instances are generated.
REQ-032 The counter width is $clog2(4/C) with a minimum of 1 bit.

Verification
REQ-033 Fwd, C=1: column 0 = db135345, columns 1-3 = f20a225c, 01010101, c6c6c6c6 -> out 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid 4 cycles after accept.
REQ-034 Inv, C=4, in 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6, with out_valid 1 cycle after accept.
REQ-035 Fwd, C=2, column d4bf5d30 replicated x4 -> 046681e5 x4 after 2 cycles; hold out_ready=0 for 10 cycles -> out_data constant and in_ready=0 throughout.
REQ-036 Round-trip: 1000 random states, fwd then inv, each C -> output equals the original; in_valid held high during RUN causes no extra accepts.
REQ-037 Reset mid-RUN (C=1, cycle 2): no out_valid; the next state is processed correctly with 4-cycle latency.
REQ-038 in_mode toggled each cycle after accept -> result matches the mode latched at accept.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: definitions shared by the MixColumns engine.
//   MODE_FWD / MODE_INV : values of the mode bit (MixColumns / InvMixColumns)
//   state_t             : control FSM states
//   gf_xtime / gf_mul   : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x (0x02). On overflow, reduce by the field polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant. Uses shift-and-add over an xtime chain,
  // which covers every MixColumns coefficient (2, 3, 9, b, d, e).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ x;
      x = gf_xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// mix_column_unit: purely combinational transform of one 32-bit AES column.
//   col    : input column, row 0 byte in [31:24]
//   mode   : MODE_FWD (MixColumns) or MODE_INV (InvMixColumns)
//   result : transformed column, same byte layout as col
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        mode,
  output logic [31:0] result
);

  logic [7:0] r [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r[i] = col[31-8*i -: 8];
    end
  end

  // Each output row is a circulant combination of the rows, indices mod 4.
  always_comb begin
    result = '0;
    for (int i = 0; i < 4; i++) begin
      if (mode == MODE_INV) begin
        result[31-8*i -: 8] = gf_mul(r[i], 4'he) ^ gf_mul(r[(i+1)%4], 4'hb) ^
                              gf_mul(r[(i+2)%4], 4'hd) ^ gf_mul(r[(i+3)%4], 4'h9);
      end else begin
        result[31-8*i -: 8] = gf_mul(r[i], 4'h2) ^ gf_mul(r[(i+1)%4], 4'h3) ^
                              r[(i+2)%4] ^ r[(i+3)%4];
      end
    end
  end

endmodule

// File: rtl/mix_column_engine.sv
// mix_column_engine: applies MixColumns / InvMixColumns to a 128-bit AES state,
// COLS_PER_CYCLE columns per clock, with a valid/ready handshake on each side.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data = state, in_mode = direction
//   out_valid/out_ready : output handshake; out_data = transformed state
//   busy                : a block is in flight or waiting to be taken
// Column c of a state occupies bits [127-32c -: 32].
module mix_column_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int OUT_REG        = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int STEPS = 4 / COLS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       work;
  logic [127:0]       work_next;
  logic               mode_q;
  logic               accept;
  logic               step;
  logic               finish;

  logic [31:0] unit_in  [COLS_PER_CYCLE];
  logic [31:0] unit_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    mix_column_unit u_col (
      .col    (unit_in[g]),
      .mode   (mode_q),
      .result (unit_out[g])
    );
  end

  // Column c belongs to group c / C and is handled by unit c % C.
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      unit_in[g] = '0;
    end
    for (int c = 0; c < 4; c++) begin
      if (cnt == CNT_W'(c / COLS_PER_CYCLE)) begin
        unit_in[c % COLS_PER_CYCLE] = work[127-32*c -: 32];
      end
    end
  end

  always_comb begin
    work_next = work;
    for (int c = 0; c < 4; c++) begin
      if (cnt == CNT_W'(c / COLS_PER_CYCLE)) begin
        work_next[127-32*c -: 32] = unit_out[c % COLS_PER_CYCLE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign finish = step && (cnt == CNT_LAST);
  assign busy   = (state != ST_IDLE);

  // Mode is captured once at accept so input changes cannot affect the block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      mode_q <= MODE_FWD;
      cnt    <= '0;
    end else if (accept) begin
      work   <= in_data;
      mode_q <= in_mode;
      cnt    <= '0;
    end else if (step) begin
      work   <= work_next;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [127:0] out_q;

    // Loaded with the final result on the last RUN cycle, cleared when taken,
    // so it reads zero everywhere except DONE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else if (finish) begin
        out_q <= work_next;
      end else if (out_valid && out_ready) begin
        out_q <= '0;
      end
    end

    assign out_data = out_q;
  end else begin : g_out_comb
    assign out_data = work;
  end

endmodule
